led_matrix_scan_reader: RTL and testbench
=========================================

Name: led_matrix_scan_reader

Overview:
- Reads the frame assembled by the per-row bidirectional shift registers and drives the 8x8 LED matrix, one row at a time.
- Consumes the concatenated parallel row outputs as a single frame word.
- Snapshots the frame at each frame boundary, so mid-frame shifts and loads never tear the displayed image.
- Inserts a blanking gap between rows to suppress ghosting.
- Signals frame boundaries to the game logic, so it can time moves.

Parameters:
- ROWS, 8, number of matrix rows scanned.
- COLS, 8, number of columns per row.
- DWELL, 1000, clock cycles each row is lit; must be >= 1.
- BLANK, 16, clock cycles all rows are off before each row is lit; 0 allowed, which skips blanking.
- COL_ACTIVE_LOW, 1, when 1 the column drive is inverted (lit LED = 0).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  request to keep scanning frames.
- frame_in  input  ROWS*COLS  live frame; row r = frame_in[r*COLS +: COLS]; bit c = column c.
- row_sel  output  ROWS  one-hot row drive, active-high; all 0 when no row is lit.
- col_out  output  COLS  column drive for the lit row (polarity per COL_ACTIVE_LOW).
- frame_start  output  1  one-cycle pulse: snapshot just taken.
- frame_done  output  1  one-cycle pulse: last row's dwell just finished.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset and synchronicity:
  - Reset is synchronous and active-high.
  - Single clock; all outputs are registered.
- Column "off" value: COL_OFF = all 1s if COL_ACTIVE_LOW, else all 0s.
- Reset state (at the clock edge with reset=1):
  - State = IDLE; row_idx = 0; counter = 0; frame_buf = 0.
  - row_sel = 0; col_out = COL_OFF.
  - frame_start = 0; frame_done = 0; busy = 0.
- Reset has priority over everything, including mid-row and mid-blank. The next cycle shows blank outputs.
- State IDLE:
  - Outputs blank; busy = 0.
  - If enable = 1 at an edge, go to LOAD.
- State LOAD (exactly 1 cycle):
  - At the exiting edge: frame_buf <= frame_in; row_idx <= 0; frame_start <= 1 for the following cycle.
  - Next state is BLANK, or SHOW if BLANK = 0.
- State BLANK:
  - row_sel = 0; col_out = COL_OFF.
  - Stays BLANK cycles, then goes to SHOW with counter cleared.
- State SHOW:
  - row_sel = one-hot(row_idx).
  - col_out = frame_buf row row_idx, inverted if COL_ACTIVE_LOW.
  - row_sel and col_out change on the same edge; there is never a cycle with a row lit and stale column data.
  - Stays DWELL cycles.
- End of SHOW, not the last row: row_idx <= row_idx + 1; go to BLANK (or SHOW directly if BLANK = 0).
- End of SHOW, last row (row_idx = ROWS-1):
  - frame_done <= 1 for 1 cycle; row_sel <= 0; col_out <= COL_OFF.
  - If enable = 1, go to LOAD; else go to IDLE.
- frame_done and frame_start never coincide. The back-to-back gap is frame_done in the LOAD cycle, then frame_start on the next cycle.
- Frame period with enable held high: 1 + ROWS*(BLANK+DWELL) cycles. Defaults give 8129.
- enable is sampled only in IDLE and at the end of the last row. Deasserting mid-frame completes the current frame (no truncation).
- frame_in changes after the snapshot have no effect until the next LOAD.
- Counter width is clog2(max(DWELL, BLANK) + 1). It saturates never and is cleared on every state change.
- row_idx never exceeds ROWS-1, and row_sel is always one-hot or zero.

Test Plan:
- Basic scan (ROWS=8, COLS=8, DWELL=4, BLANK=2, COL_ACTIVE_LOW=0):
  - Stimulus: reset 2 cycles; frame_in row r = 8'h01<<r; enable=1.
  - frame_start pulses 1 cycle after LOAD.
  - Each row shows 2 blank cycles, then row_sel=8'h01<<r with col_out=8'h01<<r for 4 cycles.
  - frame_done after 1+8*6=49 cycles from LOAD.
- Snapshot integrity:
  - Stimulus: change frame_in to all 8'hFF on the cycle after frame_start.
  - All 8 rows still show the original pattern.
  - The next frame shows 8'hFF.
- Polarity (COL_ACTIVE_LOW=1):
  - Stimulus: row 3 = 8'hA5.
  - col_out = 8'h5A while row_sel=8'h08.
  - col_out = 8'hFF during every blank cycle and in IDLE.
- Enable drop mid-frame:
  - Stimulus: deassert enable during row 2.
  - Rows 3-7 are still scanned; frame_done pulses; then IDLE with busy=0 and no further frame_start.
- Reset mid-SHOW:
  - Stimulus: assert reset while row_sel=8'h10.
  - The next cycle has row_sel=0, col_out=COL_OFF, busy=0.
  - After release with enable=1, the scan restarts at row 0.
- BLANK=0, DWELL=1:
  - row_sel steps 8'h01..8'h80 on consecutive cycles.
  - Frame period = 9 cycles.
  - Back-to-back frames show the LOAD gap cycle, with row_sel=0.

Source files
------------

// File: rtl/led_matrix_scan_reader.sv
// Row-scanning driver for an LED matrix: snapshots the assembled frame once per frame,
// then lights one row at a time with an optional blanking gap between rows.
module led_matrix_scan_reader #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DWELL          = 1000,
  parameter int BLANK          = 16,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_in,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW0       = ROWS'(1);
  localparam logic [COLS-1:0] COL_OFF    = {COLS{COL_ACTIVE_LOW}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_SHOW  = 2'd3;
  // With no blanking, every row is entered straight into SHOW.
  localparam logic [1:0] S_ROW_ENTRY = (BLANK == 0) ? S_SHOW : S_BLANK;

  logic [1:0]           state, state_nx;
  logic [RW-1:0]        row_idx, row_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [ROWS*COLS-1:0] frame_buf, buf_nx;
  logic                 row_end;

  function automatic logic [COLS-1:0] col_drive(input logic [COLS-1:0] pix);
    return COL_ACTIVE_LOW ? ~pix : pix;
  endfunction

  always_comb begin
    state_nx = state;
    row_nx   = row_idx;
    cnt_nx   = cnt + 1'b1;
    buf_nx   = frame_buf;
    row_end  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (enable) state_nx = S_LOAD;
      end
      S_LOAD: begin
        buf_nx   = frame_in;
        row_nx   = '0;
        cnt_nx   = '0;
        state_nx = S_ROW_ENTRY;
      end
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nx   = '0;
          state_nx = S_SHOW;
        end
      end
      default: begin
        if (cnt == DWELL_LAST) begin
          cnt_nx = '0;
          if (row_idx == ROW_LAST) begin
            row_end  = 1'b1;
            state_nx = enable ? S_LOAD : S_IDLE;
          end else begin
            row_nx   = row_idx + 1'b1;
            state_nx = S_ROW_ENTRY;
          end
        end
      end
    endcase
  end

  // Drives are computed from the next state so row and column switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      row_idx     <= '0;
      cnt         <= '0;
      frame_buf   <= '0;
      row_sel     <= '0;
      col_out     <= COL_OFF;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      row_idx     <= row_nx;
      cnt         <= cnt_nx;
      frame_buf   <= buf_nx;
      row_sel     <= (state_nx == S_SHOW) ? (ROW0 << row_nx) : '0;
      col_out     <= (state_nx == S_SHOW) ? col_drive(buf_nx[row_nx*COLS +: COLS]) : COL_OFF;
      frame_start <= (state == S_LOAD);
      frame_done  <= row_end;
      busy        <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_reader.sv
// Bench for led_matrix_scan_reader: three parameterisations share one stimulus stream,
// and a timeline model of each queues the expected outputs for every cycle.
module tb_led_matrix_scan_reader;

  typedef logic [18:0] vec_t;  // {row_sel, col_out, frame_start, frame_done, busy}

  localparam int DW  [3] = '{4, 4, 1};
  localparam int BL  [3] = '{2, 2, 0};
  localparam int LOW [3] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] frame_in = '0;

  logic [7:0] a_row_sel, b_row_sel, c_row_sel;
  logic [7:0] a_col_out, b_col_out, c_col_out;
  logic       a_frame_start, b_frame_start, c_frame_start;
  logic       a_frame_done, b_frame_done, c_frame_done;
  logic       a_busy, b_busy, c_busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit          run [3];
  int          t [3];
  logic [63:0] snap [3];
  logic [56:0] exp_q [$];

  always #5 clk = ~clk;

  led_matrix_scan_reader #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK(2), .COL_ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
    .row_sel(a_row_sel), .col_out(a_col_out), .frame_start(a_frame_start),
    .frame_done(a_frame_done), .busy(a_busy)
  );

  led_matrix_scan_reader #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK(2), .COL_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
    .row_sel(b_row_sel), .col_out(b_col_out), .frame_start(b_frame_start),
    .frame_done(b_frame_done), .busy(b_busy)
  );

  led_matrix_scan_reader #(.ROWS(8), .COLS(8), .DWELL(1), .BLANK(0), .COL_ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
    .row_sel(c_row_sel), .col_out(c_col_out), .frame_start(c_frame_start),
    .frame_done(c_frame_done), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Expected outputs for the cycle following this edge, derived from the cycle offset
  // since the LOAD cycle of the current frame.
  task automatic model_step(input int i, output vec_t v);
    int         per, k, row, ph;
    logic [7:0] off, rs, co;
    logic       st, dn, bz;
    per = 1 + 8 * (BL[i] + DW[i]);
    off = (LOW[i] != 0) ? 8'hFF : 8'h00;
    rs = '0; co = off; st = 1'b0; dn = 1'b0; bz = 1'b0;
    if (reset) begin
      run[i] = 1'b0;
    end else if (!run[i]) begin
      if (enable) begin
        run[i] = 1'b1;
        t[i]   = 0;
        bz     = 1'b1;
      end
    end else begin
      if (t[i] == 0) snap[i] = frame_in;
      if (t[i] == per - 1) begin
        dn = 1'b1;
        if (enable) begin
          t[i] = 0;
          bz   = 1'b1;
        end else begin
          run[i] = 1'b0;
        end
      end else begin
        t[i]++;
        bz  = 1'b1;
        st  = (t[i] == 1);
        k   = t[i] - 1;
        row = k / (BL[i] + DW[i]);
        ph  = k % (BL[i] + DW[i]);
        if (ph >= BL[i]) begin
          rs = 8'h01 << row;
          co = snap[i][row*8 +: 8] ^ off;
        end
      end
    end
    v = {rs, co, st, dn, bz};
  endtask

  always @(posedge clk) begin
    vec_t va, vb, vc;
    model_step(0, va);
    model_step(1, vb);
    model_step(2, vc);
    exp_q.push_back({va, vb, vc});
  end

  always @(negedge clk) begin
    logic [56:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("u_a cyc%0d", cyc),
            32'({a_row_sel, a_col_out, a_frame_start, a_frame_done, a_busy}), 32'(e[56:38]));
      check($sformatf("u_b cyc%0d", cyc),
            32'({b_row_sel, b_col_out, b_frame_start, b_frame_done, b_busy}), 32'(e[37:19]));
      check($sformatf("u_c cyc%0d", cyc),
            32'({c_row_sel, c_col_out, c_frame_start, c_frame_done, c_busy}), 32'(e[18:0]));
    end
  end

  task automatic wait_row(input logic [7:0] target, input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (a_row_sel == target) break;
    end
    check("wait_row_sel", 32'(a_row_sel), 32'(target));
  endtask

  task automatic wait_start(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (a_frame_start) break;
    end
    check("wait_frame_start", 32'(a_frame_start), 32'd1);
  endtask

  initial begin
    logic [63:0] base, pat2;
    for (int r = 0; r < 8; r++) base[r*8 +: 8] = 8'h01 << r;
    pat2 = base;
    pat2[3*8 +: 8] = 8'hA5;
    frame_in = base;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Scan starts; the frame is overwritten right after the snapshot.
    enable = 1'b1;
    wait_start(10);
    frame_in = '1;
    repeat (60) @(negedge clk);
    frame_in = pat2;
    repeat (60) @(negedge clk);

    // Drop enable during row 2: the frame must still complete.
    wait_row(8'h04, 120);
    enable = 1'b0;
    repeat (80) @(negedge clk);

    // Reset while row 4 is lit, then restart from row 0.
    enable = 1'b1;
    wait_row(8'h10, 120);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    enable = 1'b0;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
